uart_host_cmd_gen: RTL and testbench

Host-side command generator that drives the system's serial `RX_IN` pin. It accepts one decoded command per handshake and emits the matching byte sequence as UART frames (start, 8 data LSB-first, optional parity, stop). Byte sequences follow the system controller's command protocol: register-file write/read and ALU with or without operands. It is used as the stimulus front end in system-level benches and FPGA bring-up, clocked from the UART reference clock.

---
 rtl/uart_host_cmd_pkg.sv | 67 ++++++
 rtl/uart_host_cmd_gen_ser.sv | 133 +++++++++++++
 rtl/uart_host_cmd_gen.sv | 162 ++++++++++++++++
 tb/tb_uart_host_cmd_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_cmd_pkg.sv
// Shared types and constants for the host-side UART command generator.
// Holds the command opcode enum, the command payload struct, the frame
// header bytes, the FSM state encoding and the byte-sequence helpers.
package uart_host_cmd_pkg;

  typedef enum logic [1:0] {
    RF_WR   = 2'd0,
    RF_RD   = 2'd1,
    ALU_OP  = 2'd2,
    ALU_NOP = 2'd3
  } cmd_op_t;

  typedef struct packed {
    cmd_op_t     op;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  fun;
  } cmd_t;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;
  localparam logic [STATE_W-1:0] ST_GAP    = 3'd5;

  // Index of the final byte of a command's sequence.
  function automatic logic [1:0] cmd_last_idx(input cmd_op_t op);
    case (op)
      RF_WR:   cmd_last_idx = 2'd2;
      ALU_OP:  cmd_last_idx = 2'd3;
      default: cmd_last_idx = 2'd1;
    endcase
  endfunction

  // Byte number idx of the sequence for command c.
  function automatic logic [7:0] cmd_byte(input cmd_t c, input logic [1:0] idx);
    case (c.op)
      RF_WR: begin
        case (idx)
          2'd0:    cmd_byte = CMD_RF_WR;
          2'd1:    cmd_byte = c.addr;
          default: cmd_byte = c.data;
        endcase
      end
      RF_RD:   cmd_byte = (idx == 2'd0) ? CMD_RF_RD : c.addr;
      ALU_OP: begin
        case (idx)
          2'd0:    cmd_byte = CMD_ALU_OP;
          2'd1:    cmd_byte = c.a;
          2'd2:    cmd_byte = c.b;
          default: cmd_byte = {4'b0000, c.fun};
        endcase
      end
      default: cmd_byte = (idx == 2'd0) ? CMD_ALU_NOP : {4'b0000, c.fun};
    endcase
  endfunction

endpackage

// File: rtl/uart_host_cmd_gen_ser.sv
// Single-byte UART serializer: start bit, 8 data bits LSB first, optional
// parity bit, stop bit, each held CLKS_PER_BIT cycles.
// Optional feature macro: UART_HOST_CMD_PARITY_EN (parity state and logic).
// Ports: clk, rst_n (async active-low); load/byte_in start a frame on the
// next edge (accepted in any state); par_en/par_typ sampled with load;
// tx is the registered line; frame_done is high in the last stop-bit cycle.
module uart_byte_ser
  import uart_host_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       par_en,
  input  logic       par_typ,
  output logic       tx,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               bit_end;

  assign bit_end    = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign frame_done = (state_q == ST_STOP) && bit_end;
  assign tx         = tx_q;

`ifdef UART_HOST_CMD_PARITY_EN
  logic par_on_q, par_bit_q;

  // Parity is computed once per frame from the byte being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_on_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (load) begin
      par_on_q  <= par_en;
      par_bit_q <= (^byte_in) ^ par_typ;
    end
  end
`else
  logic unused_par;
  assign unused_par = par_en ^ par_typ;
`endif

  // Next-state and next-line value; the line value is registered so tx is glitch-free.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    bit_cnt_d = (state_q == ST_IDLE || bit_end) ? '0 : bit_cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: tx_d = 1'b1;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_HOST_CMD_PARITY_EN
            if (par_on_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else
`endif
            begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef UART_HOST_CMD_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      state_d   = ST_START;
      bit_cnt_d = '0;
      bit_idx_d = 3'd0;
      shreg_d   = byte_in;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_host_cmd_gen.sv
// Host-side command generator: accepts one command per valid/ready
// handshake and emits its 2..4 byte sequence as UART frames on TX_OUT,
// with GAP_BITS idle bit times after every stop bit.
// Optional feature macro: UART_HOST_CMD_PARITY_EN (runtime parity via PAR_EN).
// Ports: CLK, RST_n (async active-low); CMD_VALID/CMD_READY handshake;
// CMD_OP/ADDR/DATA/A/B/FUN command fields; PAR_EN/PAR_TYP parity control;
// TX_OUT serial line (idles high); BUSY; DONE one-cycle completion pulse.
module uart_host_cmd_gen
  import uart_host_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [7:0] CMD_ADDR,
  input  logic [7:0] CMD_DATA,
  input  logic [7:0] CMD_A,
  input  logic [7:0] CMD_B,
  input  logic [3:0] CMD_FUN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_OUT,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned GAP_W = 4;

  // ST_START here covers a whole frame; the serializer tracks the bit phases.
  logic [STATE_W-1:0] state_q, state_d;
  cmd_t               cmd_in, cmd_q;
  logic               par_en_q, par_typ_q;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]   gap_bit_q, gap_bit_d;
  logic               ready_q, busy_q, done_q, done_d;
  logic               hs, load, last_byte, frame_done;
  logic               ser_par_en, ser_par_typ;
  logic [7:0]         byte_in;

  assign cmd_in    = cmd_t'({CMD_OP, CMD_ADDR, CMD_DATA, CMD_A, CMD_B, CMD_FUN});
  assign hs        = CMD_VALID && (state_q == ST_IDLE);
  assign last_byte = (byte_idx_q == cmd_last_idx(cmd_q.op));

  assign CMD_READY = ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

  // Byte 0 comes straight from the inputs on the handshake edge; later bytes from the capture.
  always_comb begin
    if (state_q == ST_IDLE) begin
      byte_in     = cmd_byte(cmd_in, 2'd0);
      ser_par_en  = PAR_EN;
      ser_par_typ = PAR_TYP;
    end else begin
      byte_in     = cmd_byte(cmd_q, byte_idx_q + 2'd1);
      ser_par_en  = par_en_q;
      ser_par_typ = par_typ_q;
    end
  end

  // Byte sequencing and inter-frame gap timing.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    gap_bit_d  = gap_bit_q;
    load       = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          state_d    = ST_START;
          load       = 1'b1;
          byte_idx_d = 2'd0;
        end
      end
      ST_START: begin
        if (frame_done) begin
          if (GAP_BITS != 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
            gap_bit_d = '0;
          end else if (last_byte) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            load       = 1'b1;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          gap_cnt_d = '0;
          if (gap_bit_q == GAP_W'(GAP_BITS - 1)) begin
            if (last_byte) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d    = ST_START;
              load       = 1'b1;
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end else begin
            gap_bit_d = gap_bit_q + GAP_W'(1);
          end
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      byte_idx_q <= 2'd0;
      gap_cnt_q  <= '0;
      gap_bit_q  <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      gap_bit_q  <= gap_bit_d;
      ready_q    <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      if (hs) begin
        cmd_q     <= cmd_in;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  uart_byte_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk        (CLK),
    .rst_n      (RST_n),
    .load       (load),
    .byte_in    (byte_in),
    .par_en     (ser_par_en),
    .par_typ    (ser_par_typ),
    .tx         (TX_OUT),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_uart_host_cmd_gen.sv
// Scoreboard bench for uart_host_cmd_gen: stimulus pushes expected frames
// and DONE cycles into queues; independent monitors decode TX_OUT and DONE.
module tb_uart_host_cmd_gen;
  import uart_host_cmd_pkg::*;

  localparam int CPB = 32;
  localparam int GAP = 1;
`ifdef UART_HOST_CMD_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_ADDR, CMD_DATA, CMD_A, CMD_B;
  logic [3:0] CMD_FUN;
  logic       PAR_EN, PAR_TYP;
  logic       TX_OUT, BUSY, DONE;

  uart_host_cmd_gen #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .CLK(CLK), .RST_n(RST_n), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_A(CMD_A),
    .CMD_B(CMD_B), .CMD_FUN(CMD_FUN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .TX_OUT(TX_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    bit         has_par;
    logic       par;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Present a command, wait for acceptance, then queue its expected frames and DONE cycle.
  task automatic send(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                      input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                      input logic pe, input logic pt, input int nb,
                      input logic [0:3][7:0] bytes, input logic [0:3] pars, output int hs);
    int n = 0;
    int f;
    bit hp;
    @(negedge CLK);
    CMD_OP = op; CMD_ADDR = addr; CMD_DATA = data; CMD_A = a; CMD_B = b;
    CMD_FUN = fun; PAR_EN = pe; PAR_TYP = pt; CMD_VALID = 1'b1;
    while (!CMD_READY && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("handshake_ready", int'(CMD_READY), 1);
    if (!CMD_READY) begin
      CMD_VALID = 1'b0;
      hs = -1;
      return;
    end
    @(posedge CLK);
    #1;
    hs = cyc;
    hp = PAR_BUILD && pe;
    f  = 10 + (hp ? 1 : 0) + GAP;
    for (int i = 0; i < nb; i++)
      exp_q.push_back('{b: bytes[i], has_par: hp, par: pars[i], start: hs + i * f * CPB});
    done_q.push_back(hs + nb * f * CPB);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (!CMD_READY && n < 10000) begin
      @(negedge CLK);
      n++;
    end
    check("return_to_idle", int'(CMD_READY), 1);
    repeat (2) @(negedge CLK);
  endtask

  // Frame decoder: samples each bit mid-way and compares against the queue head.
  bit          m_busy = 1'b0;
  int          m_t, m_k;
  exp_t        m_exp;
  logic [7:0]  m_byte;
  logic        m_par;

  always @(negedge CLK) begin
    if (!RST_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (TX_OUT == 1'b0) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_byte = 8'h00;
        m_par  = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_start", int'(TX_OUT), 1);
          m_exp = '{b: 8'h00, has_par: 1'b0, par: 1'b0, start: cyc};
        end else begin
          m_exp = exp_q.pop_front();
          check("start_cycle", cyc, m_exp.start);
        end
      end
    end else begin
      m_t++;
      if (m_t % CPB == CPB / 2) begin
        m_k = m_t / CPB;
        if (m_k == 0) begin
          check("start_bit", int'(TX_OUT), 0);
        end else if (m_k <= 8) begin
          m_byte[m_k - 1] = TX_OUT;
        end else if (m_exp.has_par && m_k == 9) begin
          m_par = TX_OUT;
        end else begin
          check("stop_bit", int'(TX_OUT), 1);
          check("data_byte", int'(m_byte), int'(m_exp.b));
          if (m_exp.has_par) check("parity_bit", int'(m_par), int'(m_exp.par));
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_n && DONE) begin
      if (done_q.size() == 0) check("unexpected_done", int'(DONE), 0);
      else                    check("done_cycle", cyc, done_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual cycle %0d required < 200000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs, hs1, hs2, lows;
    RST_n = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_ADDR = 8'h00; CMD_DATA = 8'h00;
    CMD_A = 8'h00; CMD_B = 8'h00; CMD_FUN = 4'h0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_tx_out", int'(TX_OUT), 1);
    check("reset_cmd_ready", int'(CMD_READY), 1);
    check("reset_busy", int'(BUSY), 0);
    check("reset_done", int'(DONE), 0);
    RST_n = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge CLK);
      if (!TX_OUT) lows++;
    end
    check("idle_line_low_samples", lows, 0);

    // RF_WR, even parity: AA 05 3C, parity 0 0 0
    send(RF_WR, 8'h05, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 3,
         {8'hAA, 8'h05, 8'h3C, 8'h00}, 4'b0000, hs);
    CMD_VALID = 1'b0;
    check("busy_after_handshake", int'(BUSY), 1);
    wait_idle();

    // ALU_OP, odd parity: CC 12 34 01, parity 1 1 0 0
    send(ALU_OP, 8'h00, 8'h00, 8'h12, 8'h34, 4'h1, 1'b1, 1'b1, 4,
         {8'hCC, 8'h12, 8'h34, 8'h01}, 4'b1100, hs);
    CMD_VALID = 1'b0;
    wait_idle();

    // RF_RD with PAR_EN set: BB 02, even parity 0 1 when parity is built in
    send(RF_RD, 8'h02, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2,
         {8'hBB, 8'h02, 8'h00, 8'h00}, 4'b0100, hs);
    CMD_VALID = 1'b0;
    wait_idle();

    // Back-to-back: ALU_NOP then RF_RD held valid, with stray pulses while busy
    send(ALU_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 2,
         {8'hDD, 8'h03, 8'h00, 8'h00}, 4'b0000, hs1);
    CMD_VALID = 1'b0;
    repeat (150) @(negedge CLK);
    CMD_OP = RF_WR; CMD_ADDR = 8'hEE; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    repeat (300) @(negedge CLK);
    CMD_OP = ALU_OP; CMD_A = 8'h77; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    send(RF_RD, 8'h01, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 2,
         {8'hBB, 8'h01, 8'h00, 8'h00}, 4'b0000, hs2);
    check("b2b_handshake_cycle", hs2, hs1 + 2 * (10 + GAP) * CPB + 1);
    CMD_VALID = 1'b0;
    wait_idle();

    // Mid-frame reset during data bit 3 of the second byte (0x11, bit 3 = 0)
    send(RF_WR, 8'h11, 8'h22, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 3,
         {8'hAA, 8'h11, 8'h22, 8'h00}, 4'b0000, hs);
    CMD_VALID = 1'b0;
    repeat ((10 + GAP) * CPB + 4 * CPB + CPB / 2) @(negedge CLK);
    check("tx_before_reset", int'(TX_OUT), 0);
    #2;
    RST_n = 1'b0;
    #1;
    check("reset_async_tx_out", int'(TX_OUT), 1);
    check("reset_async_busy", int'(BUSY), 0);
    check("reset_async_ready", int'(CMD_READY), 1);
    exp_q.delete();
    done_q.delete();
    repeat (5) @(negedge CLK);
    RST_n = 1'b1;
    repeat (200) @(negedge CLK);

    // Fresh command after reset, odd parity: CC A5 5A 0F, parity 1 1 1 1
    send(ALU_OP, 8'h00, 8'h00, 8'hA5, 8'h5A, 4'hF, 1'b1, 1'b1, 4,
         {8'hCC, 8'hA5, 8'h5A, 8'h0F}, 4'b1111, hs);
    CMD_VALID = 1'b0;
    wait_idle();
    repeat (10) @(negedge CLK);

    check("frames_outstanding", exp_q.size(), 0);
    check("done_outstanding", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
